// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and helpers for the transmit-only UART.
//   DATA_BITS  - payload bits per frame (8N1)
//   LAST_BIT   - index of the final data bit
//   cnt_width  - width of the bit-period cycle counter for a given
//                clocks_per_bit (never narrower than one bit)
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

  function automatic int unsigned cnt_width(input int unsigned cpb);
    return (cpb <= 1) ? 1 : $clog2(cpb);
  endfunction

endpackage

// File: rtl/uart.sv
// uart: transmit-only 8N1 serialiser for a half-duplex single-wire bus.
//   clock        - system clock, rising edge
//   reset_n      - asynchronous active-low reset
//   send         - request to transmit byte_to_send (accepted while idle)
//   byte_to_send - data byte, captured on the accepting edge
//   done         - combinational ready: idle and no request pending
//   pin          - bus line; driven during a frame, released (Z) otherwise
// Each bit lasts clocks_per_bit cycles; bits go out LSB first.
module uart
  import uart_pkg::*;
#(
  parameter int unsigned clocks_per_bit = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] byte_to_send,
  output logic       done,
  inout  wire        pin
);

  localparam int unsigned CW = cnt_width(clocks_per_bit);
  localparam logic [CW-1:0] CNT_LAST = CW'(clocks_per_bit - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          bit_end;
  logic          tx_bit;
  logic          drive_en;

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_bit    = 1'b1;
    drive_en  = 1'b1;
    unique case (state)
      IDLE: begin
        drive_en = 1'b0;
        if (send) begin
          shreg_n   = byte_to_send;
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = START;
        end
      end
      START: begin
        tx_bit = 1'b0;
        if (bit_end) begin
          cnt_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      DATA: begin
        tx_bit = shreg[0];
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == LAST_BIT) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      STOP: begin
        tx_bit = 1'b1;
        if (bit_end) begin
          cnt_n = '0;
          // A request waiting at the end of the stop bit is taken on the
          // same edge that would otherwise return to IDLE, so a held
          // request streams frames with the line driven continuously.
          if (send) begin
            shreg_n   = byte_to_send;
            bit_idx_n = '0;
            state_n   = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        drive_en = 1'b0;
        state_n  = IDLE;
      end
    endcase
  end

  // Reset puts state at IDLE asynchronously, so the line is released
  // at once and a partial frame ends without a stop bit.
  assign pin  = drive_en ? tx_bit : 1'bz;
  assign done = (state == IDLE) && !send;

endmodule

// File: tb/tb_uart.sv
// tb_uart: directed, table-driven checks of the uart transmitter.
// Each clocks_per_bit setting is built twice, one copy on a pulled-up
// net and one on a pulled-down net, so a released line (Z) can be told
// apart from a driven 0 or 1.
module tb_uart;

  logic clock;
  logic rst4_n, send4;
  logic [7:0] byte4;
  logic rst1_n, send1;
  logic [7:0] byte1;
  logic done4_pu, done4_pd, done1_pu, done1_pd;
  wire  pin4_pu, pin4_pd, pin1_pu, pin1_pd;

  pullup   (pin4_pu);
  pulldown (pin4_pd);
  pullup   (pin1_pu);
  pulldown (pin1_pd);

  uart #(.clocks_per_bit(4)) u4_pu (.clock(clock), .reset_n(rst4_n), .send(send4),
    .byte_to_send(byte4), .done(done4_pu), .pin(pin4_pu));
  uart #(.clocks_per_bit(4)) u4_pd (.clock(clock), .reset_n(rst4_n), .send(send4),
    .byte_to_send(byte4), .done(done4_pd), .pin(pin4_pd));
  uart #(.clocks_per_bit(1)) u1_pu (.clock(clock), .reset_n(rst1_n), .send(send1),
    .byte_to_send(byte1), .done(done1_pu), .pin(pin1_pu));
  uart #(.clocks_per_bit(1)) u1_pd (.clock(clock), .reset_n(rst1_n), .send(send1),
    .byte_to_send(byte1), .done(done1_pd), .pin(pin1_pd));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam int PZ = 2;  // line released

  int total = 0;
  int bad   = 0;

  // Line code: 0/1 driven, 2 released, 3 inconsistent between copies.
  function automatic int code(input logic pu, input logic pd);
    if (pu === 1'b1 && pd === 1'b0) return PZ;
    if (pu === pd && (pu === 1'b0 || pu === 1'b1)) return int'(pu);
    return 3;
  endfunction

  function automatic int pin_of(input bit slow);
    return slow ? code(pin4_pu, pin4_pd) : code(pin1_pu, pin1_pd);
  endfunction

  // done as a code: 0/1 when both copies agree, 3 otherwise.
  function automatic int done_of(input bit slow);
    logic a, b;
    a = slow ? done4_pu : done1_pu;
    b = slow ? done4_pd : done1_pd;
    if (a === b && (a === 1'b0 || a === 1'b1)) return int'(a);
    return 3;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input bit slow, input logic s, input logic [7:0] b);
    if (slow) begin send4 = s; byte4 = b; end
    else      begin send1 = s; byte1 = b; end
  endtask

  // Called at a negedge: waits for idle, raises send for one edge.
  task automatic start_frame(input bit slow, input logic [7:0] data, input string nm);
    int guard;
    guard = 0;
    while (done_of(slow) != 1 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    chk({nm, "_idle_wait"}, int'(guard < 200), 1);
    set_req(slow, 1'b1, data);
    #1 chk({nm, "_done_comb"}, done_of(slow), 0);
    @(posedge clock);
    @(negedge clock);
    set_req(slow, 1'b0, ~data);  // new data must not disturb the frame
  endtask

  // Starts sampling at the negedge after the accepting edge.
  // poke >= 0: pulse send with 0xFF during that cycle of the frame.
  task automatic check_frame(input bit slow, input logic [9:0] frame, input string nm,
                             input int poke, input int idle_after);
    int cpb;
    cpb = slow ? 4 : 1;
    for (int c = 0; c < 10 * cpb; c++) begin
      chk({nm, "_pin"}, pin_of(slow), int'(frame[c / cpb]));
      chk({nm, "_busy"}, done_of(slow), 0);
      if (c == poke)     set_req(slow, 1'b1, 8'hFF);
      if (c == poke + 1) set_req(slow, 1'b0, 8'hFF);
      @(negedge clock);
    end
    chk({nm, "_end_pin"}, pin_of(slow), PZ);
    chk({nm, "_end_done"}, done_of(slow), 1);
    for (int i = 0; i < idle_after; i++) begin
      @(negedge clock);
      chk({nm, "_stay_idle"}, pin_of(slow), PZ);
    end
  endtask

  typedef struct {
    bit         slow;
    logic [7:0] data;
    logic [9:0] frame;  // bit i = i-th bit on the wire
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] f55, fFF, fFD, f3C;
    logic [7:0] seq_bytes[2];
    int idx, driven, exp;

    f55 = 10'b1_01010101_0;
    fFF = 10'b1_11111111_0;
    fFD = 10'b1_11111101_0;
    f3C = 10'b1_00111100_0;
    vecs[0] = '{1'b1, 8'hA5, 10'b1_10100101_0};
    vecs[1] = '{1'b1, 8'h3C, 10'b1_00111100_0};
    vecs[2] = '{1'b1, 8'h81, 10'b1_10000001_0};
    vecs[3] = '{1'b0, 8'hFF, 10'b1_11111111_0};
    vecs[4] = '{1'b0, 8'h00, 10'b1_00000000_0};
    vecs[5] = '{1'b0, 8'hA5, 10'b1_10100101_0};

    rst4_n = 1'b0; rst1_n = 1'b0;
    send4 = 1'b0; send1 = 1'b0; byte4 = 8'h00; byte1 = 8'h00;
    #1;
    chk("reset_pin4", pin_of(1'b1), PZ);
    chk("reset_done4", done_of(1'b1), 1);
    chk("reset_pin1", pin_of(1'b0), PZ);
    chk("reset_done1", done_of(1'b0), 1);
    @(negedge clock);
    rst4_n = 1'b1; rst1_n = 1'b1;
    @(negedge clock);
    chk("post_reset_pin4", pin_of(1'b1), PZ);

    // Single frames from the table.
    foreach (vecs[v]) begin
      start_frame(vecs[v].slow, vecs[v].data, $sformatf("vec%0d", v));
      check_frame(vecs[v].slow, vecs[v].frame, $sformatf("vec%0d", v), -1, 2);
    end

    // Mid-frame send pulse with new byte: frame keeps 0x00, no extra frame.
    start_frame(1'b1, 8'h00, "midpoke");
    check_frame(1'b1, 10'b1_00000000_0, "midpoke", 15, 12);

    // Reset during data bit 3 of 0x3C (cycles 16..19 at cpb=4).
    start_frame(1'b1, 8'h3C, "rst_mid");
    for (int c = 0; c < 18; c++) begin
      chk("rst_mid_pin", pin_of(1'b1), int'(f3C[c / 4]));
      @(negedge clock);
    end
    rst4_n = 1'b0;
    #1;
    chk("rst_mid_release", pin_of(1'b1), PZ);
    chk("rst_mid_done", done_of(1'b1), 1);
    @(negedge clock);
    chk("rst_mid_hold", pin_of(1'b1), PZ);
    rst4_n = 1'b1;
    @(negedge clock);
    chk("rst_after_pin", pin_of(1'b1), PZ);
    chk("rst_after_done", done_of(1'b1), 1);
    start_frame(1'b1, 8'h3C, "rst_fresh");
    check_frame(1'b1, f3C, "rst_fresh", -1, 0);

    // send held for 25 edges at cpb=1: frames chain with no gap.
    @(negedge clock);
    set_req(1'b0, 1'b1, 8'h55);
    #1 chk("hold_done_comb", done_of(1'b0), 0);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      chk("hold_pin", pin_of(1'b0), int'(f55[(n - 1) % 10]));
      chk("hold_busy", done_of(1'b0), 0);
      if (n == 25) set_req(1'b0, 1'b0, 8'h55);
    end
    @(negedge clock);
    chk("hold_end_pin", pin_of(1'b0), PZ);
    chk("hold_end_done", done_of(1'b0), 1);

    // Sequencer pacing on done: 0xFF then 0xFD, one-cycle requests.
    seq_bytes[0] = 8'hFF;
    seq_bytes[1] = 8'hFD;
    idx = 0;
    driven = 0;
    @(negedge clock);
    for (int t = 0; t < 30; t++) begin
      if (t == 0 || t == 11 || t >= 22) exp = PZ;
      else if (t <= 10)                 exp = int'(fFF[t - 1]);
      else                              exp = int'(fFD[t - 12]);
      chk("seq_pin", pin_of(1'b0), exp);
      if (pin_of(1'b0) != PZ) driven++;
      if (done_of(1'b0) == 1 && idx < 2) begin
        set_req(1'b0, 1'b1, seq_bytes[idx]);
        idx++;
        #1 chk("seq_done_comb", done_of(1'b0), 0);
      end else begin
        set_req(1'b0, 1'b0, 8'h00);
      end
      @(negedge clock);
    end
    chk("seq_driven_cycles", driven, 20);
    chk("seq_bytes_sent", idx, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
